// File: rtl/cell_free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cell_free_list_pkg
// Description : Types shared by cell_free_list and its storage sub-module.
//               fl_state_e - controller state (INIT populates the list,
//                            RUN serves alloc/free traffic).
// Revision    : 1.0 - initial release
// ============================================================================
package cell_free_list_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fl_state_e;

endpackage : cell_free_list_pkg
`default_nettype wire

// File: rtl/rv_p4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_p4_pkg
// Description : Project-wide constants shared by the packet-buffer blocks.
//               CELL_ID_W   - width of a packet-buffer cell identifier.
//               PB_CELL_CNT - number of cells in the shared packet buffer,
//                             used to size cell_free_list at the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_p4_pkg;

  localparam int CELL_ID_W   = 8;
  localparam int PB_CELL_CNT = 256;

endpackage : rv_p4_pkg
`default_nettype wire

// File: rtl/cell_fl_mem.sv
`default_nettype none
// ============================================================================
// Module      : cell_fl_mem
// Description : Free-list storage: DEPTH x ID_W flop array with one
//               synchronous write port and one asynchronous read port.
// Ports       : clk   - clock
//               we    - write enable
//               waddr - write slot
//               wdata - cell ID written into the slot
//               raddr - read slot
//               rdata - cell ID held in slot raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module cell_fl_mem
  import cell_free_list_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [ID_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [ID_W-1:0] rdata
);

  // Contents are fully rewritten by the INIT sweep after every reset,
  // so the array itself carries no reset.
  logic [ID_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : cell_fl_mem
`default_nettype wire

// File: rtl/cell_free_list.sv
`default_nettype none
// ============================================================================
// Module      : cell_free_list
// Description : Multi-channel packet-buffer cell allocator. Keeps every free
//               cell ID in a FIFO free list, fills the list itself after
//               reset, round-robin arbitrates NUM_CH alloc and free channels
//               and flags double-frees / out-of-range frees.
// Ports       : clk, rst_n       - clock, async active-low reset
//               alloc_req/gnt    - per-channel request, one-hot grant
//               alloc_id         - granted ID (valid while a grant is high)
//               free_req/ack     - per-channel free request, one-hot accept
//               free_id          - packed per-channel IDs to free
//               free_cnt         - number of free cells
//               alloc_empty      - no grant possible this cycle
//               low_wm           - free_cnt below LOW_WM
//               init_done        - free list populated
//               err_dfree/err_id - bad-free pulse and offending ID
// Revision    : 1.0 - initial release
// ============================================================================
module cell_free_list
  import rv_p4_pkg::*;
  import cell_free_list_pkg::*;
#(
  parameter  int ID_W     = CELL_ID_W,
  parameter  int CELL_CNT = 2**ID_W,
  parameter  int NUM_CH   = 4,
  parameter  int LOW_WM   = 64,
  localparam int CNT_W    = $clog2(CELL_CNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      alloc_req,
  output logic [NUM_CH-1:0]      alloc_gnt,
  output logic [ID_W-1:0]        alloc_id,
  input  logic [NUM_CH-1:0]      free_req,
  input  logic [NUM_CH*ID_W-1:0] free_id,
  output logic [NUM_CH-1:0]      free_ack,
  output logic [CNT_W-1:0]       free_cnt,
  output logic                   alloc_empty,
  output logic                   low_wm,
  output logic                   init_done,
  output logic                   err_dfree,
  output logic [ID_W-1:0]        err_id
);

  localparam int PTR_W = (CELL_CNT > 1) ? $clog2(CELL_CNT) : 1;
  localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAP_N = 2**ID_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CELL_CNT - 1);
  localparam logic [RR_W-1:0]  CH_LAST  = RR_W'(NUM_CH - 1);

  fl_state_e         state;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  // Round-robin pointers hold the channel with highest priority next,
  // i.e. one past the last winner.
  logic [RR_W-1:0]   alloc_rr;
  logic [RR_W-1:0]   free_rr;
  // Sized for the full ID space so any free_id can index it; only the
  // first CELL_CNT bits are ever set.
  logic [MAP_N-1:0]  in_use;

  // Returns {found, channel}: first asserted request scanning upward from
  // 'start' with wrap-around.
  function automatic logic [RR_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [RR_W-1:0]   start);
    logic            found;
    logic [RR_W-1:0] sel;
    int              idx;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = RR_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] c);
    return (c == CH_LAST) ? '0 : c + RR_W'(1);
  endfunction

  // CELL_CNT need not be a power of two, so wrap by compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [RR_W:0]    a_pick;
  logic [RR_W:0]    f_pick;
  logic [RR_W-1:0]  a_sel;
  logic [RR_W-1:0]  f_sel;
  logic             can_alloc;
  logic             do_alloc;
  logic             do_free;
  logic [ID_W-1:0]  fid;
  logic             fid_ok;
  logic             free_valid;
  logic             mem_we;
  logic [ID_W-1:0]  mem_wdata;

  assign a_pick    = rr_pick(alloc_req, alloc_rr);
  assign f_pick    = rr_pick(free_req, free_rr);
  assign a_sel     = a_pick[RR_W-1:0];
  assign f_sel     = f_pick[RR_W-1:0];

  // Only registered count gates allocation: a cell freed this cycle is not
  // grantable until the next one.
  assign can_alloc = (state == ST_RUN) && (free_cnt != '0);
  assign do_alloc  = can_alloc && a_pick[RR_W];
  assign do_free   = (state == ST_RUN) && f_pick[RR_W];

  assign fid       = free_id[int'(f_sel)*ID_W +: ID_W];
  // An ID allocated in this same cycle still reads as not-in-use, so it is
  // treated as a double-free.
  assign fid_ok    = (32'(fid) < 32'(CELL_CNT)) && in_use[fid];
  assign free_valid = do_free && fid_ok;

  always_comb begin
    alloc_gnt = '0;
    free_ack  = '0;
    if (do_alloc) alloc_gnt[a_sel] = 1'b1;
    if (do_free)  free_ack[f_sel]  = 1'b1;
  end

  assign alloc_empty = !can_alloc;
  assign low_wm      = 32'(free_cnt) < 32'(LOW_WM);

  // INIT writes slot k with ID k; afterwards only valid frees write.
  assign mem_we    = (state == ST_INIT) || free_valid;
  assign mem_wdata = (state == ST_INIT) ? ID_W'(wr_ptr) : fid;

  cell_fl_mem #(
    .ID_W  (ID_W),
    .DEPTH (CELL_CNT),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (mem_wdata),
    .raddr (rd_ptr),
    .rdata (alloc_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      alloc_rr  <= '0;
      free_rr   <= '0;
      in_use    <= '0;
      free_cnt  <= '0;
      init_done <= 1'b0;
      err_dfree <= 1'b0;
      err_id    <= '0;
    end else begin
      err_dfree <= 1'b0;
      case (state)
        ST_INIT: begin
          wr_ptr   <= ptr_inc(wr_ptr);
          free_cnt <= free_cnt + CNT_W'(1);
          if (wr_ptr == PTR_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (do_alloc) begin
            rd_ptr           <= ptr_inc(rd_ptr);
            in_use[alloc_id] <= 1'b1;
            alloc_rr         <= rr_next(a_sel);
          end
          if (do_free) begin
            free_rr <= rr_next(f_sel);
            if (fid_ok) begin
              wr_ptr      <= ptr_inc(wr_ptr);
              in_use[fid] <= 1'b0;
            end else begin
              err_dfree <= 1'b1;
              err_id    <= fid;
            end
          end
          if (do_alloc && !free_valid) begin
            free_cnt <= free_cnt - CNT_W'(1);
          end else if (!do_alloc && free_valid) begin
            free_cnt <= free_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule : cell_free_list
`default_nettype wire

// File: tb/tb_cell_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_free_list
// Description : Self-checking bench for cell_free_list. Instance A has
//               CELL_CNT=8, instance B has CELL_CNT=6 for the wrap scenario.
//               Expected values come from a FIFO/queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_free_list;

  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int CCA = 8;
  localparam int CCB = 6;
  localparam int LWM = 3;

  logic clk;
  logic rst_n_a, rst_n_b;

  logic [N-1:0]     a_areq, a_gnt, a_freq, a_ack;
  logic [N*IDW-1:0] a_fid;
  logic [IDW-1:0]   a_id, a_errid;
  logic [3:0]       a_cnt;
  logic             a_empty, a_low, a_done, a_err;

  logic [N-1:0]     b_areq, b_gnt, b_freq, b_ack;
  logic [N*IDW-1:0] b_fid;
  logic [IDW-1:0]   b_id, b_errid;
  logic [2:0]       b_cnt;
  logic             b_empty, b_low, b_done, b_err;

  cell_free_list #(.ID_W(IDW), .CELL_CNT(CCA), .NUM_CH(N), .LOW_WM(LWM)) u_a (
    .clk(clk), .rst_n(rst_n_a), .alloc_req(a_areq), .alloc_gnt(a_gnt),
    .alloc_id(a_id), .free_req(a_freq), .free_id(a_fid), .free_ack(a_ack),
    .free_cnt(a_cnt), .alloc_empty(a_empty), .low_wm(a_low),
    .init_done(a_done), .err_dfree(a_err), .err_id(a_errid));

  cell_free_list #(.ID_W(IDW), .CELL_CNT(CCB), .NUM_CH(N), .LOW_WM(LWM)) u_b (
    .clk(clk), .rst_n(rst_n_b), .alloc_req(b_areq), .alloc_gnt(b_gnt),
    .alloc_id(b_id), .free_req(b_freq), .free_id(b_fid), .free_ack(b_ack),
    .free_cnt(b_cnt), .alloc_empty(b_empty), .low_wm(b_low),
    .init_done(b_done), .err_dfree(b_err), .err_id(b_errid));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- reference model for instance A ----------------
  int   mq[$];          // free list, head is next to allocate
  bit   minuse[16];
  int   m_arr, m_frr;   // channel with highest priority next
  bit   m_err;
  int   m_errid;
  logic [N-1:0] e_gnt, e_ack;
  int   e_id, e_gc, e_fc, e_fidv;
  bit   e_fvalid;

  function automatic int pick(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++) begin
      if (req[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic int pick_inuse();
    int u[$];
    for (int i = 0; i < CCA; i++) if (minuse[i]) u.push_back(i);
    if (u.size() == 0) return int'($urandom_range(0, 15));
    return u[$urandom_range(0, u.size() - 1)];
  endfunction

  task automatic model_init();
    mq.delete();
    for (int k = 0; k < CCA; k++) mq.push_back(k);
    for (int k = 0; k < 16; k++) minuse[k] = 1'b0;
    m_arr = 0; m_frr = 0; m_err = 1'b0; m_errid = 0;
  endtask

  task automatic model_eval();
    e_gnt = '0; e_ack = '0; e_id = -1; e_gc = -1; e_fvalid = 1'b0; e_fidv = 0;
    if (mq.size() > 0) begin
      e_gc = pick(a_areq, m_arr);
      if (e_gc >= 0) begin e_gnt[e_gc] = 1'b1; e_id = mq[0]; end
    end
    e_fc = pick(a_freq, m_frr);
    if (e_fc >= 0) begin
      e_ack[e_fc] = 1'b1;
      e_fidv   = int'(a_fid[e_fc*IDW +: IDW]);
      e_fvalid = (e_fidv < CCA) && minuse[e_fidv];
    end
  endtask

  task automatic model_commit();
    if (e_gc >= 0) begin
      void'(mq.pop_front());
      minuse[e_id] = 1'b1;
      m_arr = (e_gc + 1) % N;
    end
    m_err = 1'b0;
    if (e_fc >= 0) begin
      m_frr = (e_fc + 1) % N;
      if (e_fvalid) begin mq.push_back(e_fidv); minuse[e_fidv] = 1'b0; end
      else begin m_err = 1'b1; m_errid = e_fidv; end
    end
  endtask

  task automatic clock_model();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    a_areq = '1; a_freq = '1; a_fid = 16'h3210;
    b_areq = '0; b_freq = '0; b_fid = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (a_gnt !== 4'h0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", a_gnt); end
    n_chk++; if (a_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", a_ack); end
    n_chk++; if (a_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    n_chk++; if ({a_empty, a_low, a_done, a_err} !== 4'b1100) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=1100 (empty,low,done,err)", {a_empty, a_low, a_done, a_err}); end
    n_chk++; if (a_errid !== 4'd0) begin n_fail++; $display("FAIL reset_errid got=%0d exp=0", a_errid); end
  endtask

  task automatic test_init();
    a_freq = '0; a_areq = 4'b0001;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    for (int k = 1; k <= CCA; k++) begin
      @(negedge clk);
      n_chk++; if (a_cnt !== 4'(k)) begin n_fail++; $display("FAIL init_cnt k=%0d got=%0d exp=%0d", k, a_cnt, k); end
      n_chk++; if (a_done !== (k == CCA)) begin n_fail++; $display("FAIL init_done k=%0d got=%b exp=%b", k, a_done, k == CCA); end
      if (k < CCA) begin
        n_chk++; if (a_gnt !== 4'h0) begin n_fail++; $display("FAIL init_gnt k=%0d got=%b exp=0000", k, a_gnt); end
      end
    end
    a_areq = '0;
    model_init();
  endtask

  task automatic test_fairness();
    int expch[5] = '{0, 1, 2, 3, 0};
    a_areq = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1; model_eval();
      n_chk++; if (a_gnt !== 4'(1 << expch[i])) begin n_fail++; $display("FAIL fair_gnt i=%0d got=%b exp=%b", i, a_gnt, 4'(1 << expch[i])); end
      n_chk++; if (a_id !== 4'(i)) begin n_fail++; $display("FAIL fair_id i=%0d got=%0d exp=%0d", i, a_id, i); end
      clock_model();
    end
    a_areq = '0;
    n_chk++; if ({a_cnt, a_low} !== {4'd3, 1'b0}) begin n_fail++; $display("FAIL fair_cnt got=%0d/%b exp=3/0", a_cnt, a_low); end
  endtask

  task automatic test_midrun_reset();
    // Return IDs 3 and 4 so exactly 0,1,2 stay allocated.
    for (int i = 0; i < 2; i++) begin
      a_freq = 4'(1 << (i + 1)); a_fid = '0; a_fid[(i+1)*IDW +: IDW] = 4'(3 + i);
      #1; model_eval();
      n_chk++; if (a_ack !== e_ack) begin n_fail++; $display("FAIL mr_ack i=%0d got=%b exp=%b", i, a_ack, e_ack); end
      clock_model();
    end
    a_freq = '0;
    rst_n_a = 1'b0; a_areq = 4'hF;
    #1;
    n_chk++; if ({a_gnt, a_ack, a_cnt} !== 12'h000) begin n_fail++; $display("FAIL mr_rst_vals got=%b/%b/%0d exp=0/0/0", a_gnt, a_ack, a_cnt); end
    n_chk++; if ({a_empty, a_low, a_done, a_err} !== 4'b1100) begin n_fail++;
      $display("FAIL mr_rst_flags got=%b exp=1100", {a_empty, a_low, a_done, a_err}); end
    @(negedge clk);
    a_areq = '0; rst_n_a = 1'b1;
    repeat (CCA) @(negedge clk);
    n_chk++; if ({a_done, a_cnt} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL mr_reinit got=%b/%0d exp=1/8", a_done, a_cnt); end
    model_init();
    // ID 2 was allocated before reset; it is forgotten now.
    a_freq = 4'b1000; a_fid = '0; a_fid[3*IDW +: IDW] = 4'd2;
    #1; model_eval();
    n_chk++; if (a_ack !== 4'b1000) begin n_fail++; $display("FAIL mr_stale_ack got=%b exp=1000", a_ack); end
    clock_model();
    n_chk++; if ({a_err, a_errid, a_cnt} !== {1'b1, 4'd2, 4'd8}) begin n_fail++;
      $display("FAIL mr_stale_err got=%b/%0d/%0d exp=1/2/8", a_err, a_errid, a_cnt); end
    a_freq = '0;
    #1; model_eval(); clock_model();
    n_chk++; if ({a_err, a_errid} !== {1'b0, 4'd2}) begin n_fail++; $display("FAIL mr_err_pulse got=%b/%0d exp=0/2", a_err, a_errid); end
  endtask

  task automatic test_fifo_order();
    a_areq = 4'b0001;
    for (int k = 0; k < CCA; k++) begin
      #1; model_eval();
      n_chk++; if (a_gnt !== 4'b0001) begin n_fail++; $display("FAIL fifo_gnt k=%0d got=%b exp=0001", k, a_gnt); end
      n_chk++; if (a_id !== 4'(k)) begin n_fail++; $display("FAIL fifo_id k=%0d got=%0d exp=%0d", k, a_id, k); end
      clock_model();
    end
    n_chk++; if ({a_empty, a_cnt} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL fifo_empty got=%b/%0d exp=1/0", a_empty, a_cnt); end
    #1;
    n_chk++; if (a_gnt !== 4'h0) begin n_fail++; $display("FAIL fifo_nogrant got=%b exp=0000", a_gnt); end
  endtask

  task automatic test_empty_bypass();
    a_areq = 4'b0001; a_freq = 4'b0010; a_fid = '0; a_fid[1*IDW +: IDW] = 4'd5;
    #1; model_eval();
    n_chk++; if ({a_gnt, a_ack} !== 8'b0000_0010) begin n_fail++; $display("FAIL byp_same got=%b/%b exp=0000/0010", a_gnt, a_ack); end
    clock_model();
    a_freq = '0;
    #1; model_eval();
    n_chk++; if ({a_gnt, a_id} !== {4'b0001, 4'd5}) begin n_fail++; $display("FAIL byp_next got=%b/%0d exp=0001/5", a_gnt, a_id); end
    clock_model();
    a_areq = '0;
  endtask

  task automatic test_double_free();
    a_freq = 4'b0100; a_fid = '0; a_fid[2*IDW +: IDW] = 4'd3;
    for (int i = 0; i < 2; i++) begin
      #1; model_eval();
      n_chk++; if (a_ack !== 4'b0100) begin n_fail++; $display("FAIL df_ack i=%0d got=%b exp=0100", i, a_ack); end
      clock_model();
      n_chk++; if ({a_err, a_cnt} !== {1'(i == 1), 4'd1}) begin n_fail++;
        $display("FAIL df_state i=%0d got=%b/%0d exp=%b/1", i, a_err, a_cnt, i == 1); end
    end
    n_chk++; if (a_errid !== 4'd3) begin n_fail++; $display("FAIL df_errid got=%0d exp=3", a_errid); end
    a_freq = '0;
    #1; model_eval(); clock_model();
    n_chk++; if ({a_err, a_errid} !== {1'b0, 4'd3}) begin n_fail++; $display("FAIL df_pulse got=%b/%0d exp=0/3", a_err, a_errid); end
    a_freq = 4'b0001; a_fid = '0; a_fid[0 +: IDW] = 4'd9;
    #1; model_eval();
    n_chk++; if (a_ack !== 4'b0001) begin n_fail++; $display("FAIL oor_ack got=%b exp=0001", a_ack); end
    clock_model();
    n_chk++; if ({a_err, a_errid, a_cnt} !== {1'b1, 4'd9, 4'd1}) begin n_fail++;
      $display("FAIL oor_err got=%b/%0d/%0d exp=1/9/1", a_err, a_errid, a_cnt); end
    a_freq = '0;
    #1; model_eval(); clock_model();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_areq = 4'($urandom_range(0, 15));
      a_freq = 4'($urandom_range(0, 15));
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) < 7) a_fid[c*IDW +: IDW] = 4'(pick_inuse());
        else                          a_fid[c*IDW +: IDW] = 4'($urandom_range(0, 15));
      end
      #1; model_eval();
      n_chk++; if (a_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, a_gnt, e_gnt); end
      if (e_gc >= 0) begin
        n_chk++; if (a_id !== 4'(e_id)) begin n_fail++; $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", cyc, a_id, e_id); end
      end
      n_chk++; if (a_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, a_ack, e_ack); end
      clock_model();
      n_chk++; if (a_cnt !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, a_cnt, mq.size()); end
      n_chk++; if ({a_empty, a_low} !== {1'(mq.size() == 0), 1'(mq.size() < LWM)}) begin n_fail++;
        $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", cyc, a_empty, a_low, mq.size() == 0, mq.size() < LWM); end
      n_chk++; if ({a_err, a_errid} !== {m_err, 4'(m_errid)}) begin n_fail++;
        $display("FAIL rnd_err cyc=%0d got=%b/%0d exp=%b/%0d", cyc, a_err, a_errid, m_err, m_errid); end
    end
    a_areq = '0; a_freq = '0;
  endtask

  task automatic test_wrap();
    int fl[$];
    int held[$];
    int got;
    n_chk++; if ({b_done, b_cnt} !== {1'b1, 3'd6}) begin n_fail++; $display("FAIL wrap_ready got=%b/%0d exp=1/6", b_done, b_cnt); end
    b_areq = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if ({b_gnt, b_id} !== {4'b0001, 4'(k)}) begin n_fail++; $display("FAIL wrap_pre k=%0d got=%b/%0d exp=0001/%0d", k, b_gnt, b_id, k); end
      @(negedge clk);
      held.push_back(k);
    end
    for (int k = 3; k < CCB; k++) fl.push_back(k);
    b_freq = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      b_fid = '0; b_fid[1*IDW +: IDW] = 4'(held[0]);
      #1;
      got = int'(b_id);
      n_chk++; if ({b_gnt, b_ack, b_id} !== {4'b0001, 4'b0010, 4'(fl[0])}) begin n_fail++;
        $display("FAIL wrap_pair i=%0d got=%b/%b/%0d exp=0001/0010/%0d", i, b_gnt, b_ack, b_id, fl[0]); end
      n_chk++; if (got inside {held}) begin n_fail++; $display("FAIL wrap_dup i=%0d got=%0d exp=not-held", i, got); end
      @(posedge clk);
      fl.push_back(held.pop_front());
      held.push_back(fl.pop_front());
      @(negedge clk);
      n_chk++; if ({b_cnt, b_err} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL wrap_cnt i=%0d got=%0d/%b exp=3/0", i, b_cnt, b_err); end
    end
    b_areq = '0; b_freq = '0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_fairness();
    test_midrun_reset();
    test_fifo_order();
    test_empty_bypass();
    test_double_free();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cell_free_list
`default_nettype wire

// File: doc/cell_free_list.md
# cell_free_list

Parametrised multi-channel cell allocator for the shared packet buffer. It is the next generation of the single-requester alloc/free handshake. It holds every free cell ID in a FIFO free list and self-initialises after reset. It round-robin arbitrates up to NUM_CH allocate and free channels, and detects double-frees. It sits beside pkt_buffer: Parser instances allocate cells, and the TM/Deparser instances free them.

## Interface
- ID_W, default CELL_ID_W (rv_p4_pkg): cell ID width.
- CELL_CNT, default 2**ID_W: number of cells managed, 2..2**ID_W; need not be a power of two.
- NUM_CH, default 4: number of alloc/free channels, 1..16.
- LOW_WM, default 64: low-watermark threshold on the free count.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- alloc_req  in  NUM_CH  per-channel allocate request; held until granted.
- alloc_gnt  out  NUM_CH  one-hot grant; at most one bit per cycle.
- alloc_id  out  ID_W  allocated ID; valid only while some alloc_gnt bit is 1.
- free_req  in  NUM_CH  per-channel free request; held with free_id until acked.
- free_id  in  NUM_CH*ID_W  ID to free; channel c uses bits [c*ID_W +: ID_W].
- free_ack  out  NUM_CH  one-hot accept; at most one bit per cycle.
- free_cnt  out  $clog2(CELL_CNT+1)  number of free cells.
- alloc_empty  out  1  high when no grant is possible.
- low_wm  out  1  free_cnt < LOW_WM.
- init_done  out  1  free list populated.
- err_dfree  out  1  1-cycle pulse on a double-free or an out-of-range free.
- err_id  out  ID_W  offending ID; holds its value until the next error.

## Operation
- FSM states: INIT, RUN.
- INIT (entered on reset):
  - Write ID k into list slot k in cycle k, for k = 0..CELL_CNT-1.
  - free_cnt increments each cycle.
  - All grants and acks are 0.
  - After the write of ID CELL_CNT-1, move to RUN; init_done goes to 1 in that same edge.
- RUN, alloc path:
  - Round-robin among asserted alloc_req bits. Priority starts at the channel after the last granted channel.
  - A grant is possible only when free_cnt > 0.
  - alloc_gnt and alloc_id are combinational in the request cycle. alloc_id is the head of the list (async read).
  - On the clock edge: advance rd_ptr and set the ID's in-use bit.
- RUN, free path:
  - Separate round-robin pointer over asserted free_req bits; one ack per cycle.
  - Valid free (ID < CELL_CNT and its in-use bit is set): write at wr_ptr, advance wr_ptr, clear the in-use bit.
  - Invalid free (in-use bit clear, or ID >= CELL_CNT): still ack, discard the ID, pulse err_dfree next cycle, load err_id.
- An alloc and a free in the same cycle both proceed; free_cnt is unchanged.
- No bypass: when free_cnt = 0, an ID freed in cycle T is first grantable in cycle T+1.
- Allocating and freeing the same ID in one cycle is illegal: the in-use bit is not yet set. Treat it as a double-free.
- Pointers wrap from CELL_CNT-1 to 0 by explicit compare, not by modulo-2^n.
- free_cnt never exceeds CELL_CNT; invalid frees are excluded, so overflow is impossible.
- An RR pointer advances only on a grant or ack.

## Timing
- Reset values:
  - Outputs: alloc_gnt=0, free_ack=0, free_cnt=0, alloc_empty=1, low_wm=1, init_done=0, err_dfree=0, err_id=0.
  - Internal: rd_ptr=wr_ptr=0, both RR pointers=0, in-use bitmap all 0.
- INIT lasts exactly CELL_CNT cycles after rst_n deasserts. The first grant is possible in cycle CELL_CNT.
- Alloc latency is 0 cycles (same cycle as the request). Free takes effect in free_cnt 1 cycle later.
- alloc_empty, low_wm and free_cnt are registered or derived from registered state only.
- Reset asserted mid-operation aborts everything. On release, INIT restarts and all previously allocated IDs are forgotten.

## Structure
- rv_p4_pkg supplies CELL_ID_W, plus a new constant PB_CELL_CNT used as the top-level CELL_CNT override.
- Sub-module cell_fl_mem holds the storage: CELL_CNT x ID_W flop array, one write port, async read.
- The in-use bitmap, round-robin arbiters and FSM stay in cell_free_list.
- The arbiter is a local function, not a module.

## Test plan
- Init with CELL_CNT=8:
  - init_done rises after 8 cycles; free_cnt=8.
  - Continuous alloc on channel 0 returns IDs 0..7 in order.
  - alloc_empty=1 after the 8th grant.
- Fairness, NUM_CH=4: all alloc_req held → grants rotate 0,1,2,3,0. No channel is granted twice in a row while others wait.
- Empty list: with free_cnt=0, free ID 5 while alloc_req is held → no grant that cycle; grant with alloc_id=5 the next cycle.
- Double-free:
  - Free ID 3 twice; the second is acked.
  - err_dfree pulses one cycle with err_id=3; free_cnt is unchanged by the second free.
  - Freeing ID 9 with CELL_CNT=8 also errors.
- Wrap-around, CELL_CNT=6: 20 alloc/free pairs in the same cycles.
  - free_cnt stays constant throughout.
  - IDs cycle in FIFO order across the pointer wrap with no duplicates.
  - No errors.
- Reset mid-run: assert rst_n=0 while 3 IDs are allocated.
  - All outputs return to their reset values.
  - INIT replays; a later free of a pre-reset ID flags err_dfree.
